// File: rtl/ps2_mouse_sequence_fifo.sv
// ps2_mouse_sequence_fifo
//   Byte-serializing FIFO that sits behind the PS/2 mouse ASCII encoder.
//   Each push carries a whole sequence of up to 4 bytes. The FIFO either
//   stores every byte of the sequence or stores none of them, so a mouse
//   report is never truncated. Bytes leave one per cycle on a valid/ready
//   stream.
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous, active-low reset
//   sequence_in       up to 4 bytes; the first byte to send is in [31:24]
//   sequence_in_count number of valid bytes (0 = no push; 5..7 count as 4)
//   byte_out          head byte, or 8'h00 when the FIFO is empty
//   byte_out_valid    FIFO holds at least one byte
//   byte_out_ready    consumer takes byte_out this cycle
//   fifo_level        number of bytes stored
//   overflow          sticky flag: at least one sequence was dropped
//   overflow_clear    synchronous clear of overflow (a drop in the same cycle wins)

module ps2_mouse_sequence_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           sequence_in,
  input  logic [2:0]            sequence_in_count,
  output logic [7:0]            byte_out,
  output logic                  byte_out_valid,
  input  logic                  byte_out_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  localparam int unsigned CAPACITY = 1 << DEPTH_LOG2;
  localparam int unsigned LW       = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] CAP_L = LW'(CAPACITY);

  logic [7:0]            storage [CAPACITY];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   level;

  logic [2:0]            push_n;
  logic [DEPTH_LOG2:0]   free_slots;
  logic                  push_ok;
  logic                  drop;
  logic                  pop;
  logic [7:0]            seq_byte [4];

  // Counts 4..7 all mean a full 4-byte sequence.
  assign push_n     = sequence_in_count[2] ? 3'd4 : sequence_in_count;
  // Room is judged on the level before this cycle's pop; a pop in the same
  // cycle does not make space for the push.
  assign free_slots = CAP_L - level;
  assign push_ok    = (push_n != 3'd0) && (LW'(push_n) <= free_slots);
  assign drop       = (push_n != 3'd0) && !push_ok;
  assign pop        = (level != '0) && byte_out_ready;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      seq_byte[i] = sequence_in[8*(3-i) +: 8];
    end
  end

  // Storage is deliberately not reset. The slot index wraps modulo CAPACITY,
  // so a sequence that straddles the end of the array continues at slot 0.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (i < 32'(push_n)) begin
          storage[wr_ptr + DEPTH_LOG2'(i)] <= seq_byte[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(push_n);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + LW'(push_ok ? push_n : 3'd0) - LW'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clear) begin
        overflow <= 1'b0;
      end
    end
  end

  assign byte_out_valid = (level != '0);
  assign byte_out       = byte_out_valid ? storage[rd_ptr] : 8'h00;
  assign fifo_level     = level;

endmodule
